rms_norm_stream: RTL and testbench
==================================

Name: rms_norm_stream

Overview:
- Streaming RMS-normalisation unit for the ternary matmul AFU datapath; a parametrised successor to the single-shot vector RMS block.
- Accepts a DIM-element signed fixed-point vector as DIM/LANES input beats and buffers it internally.
- Computes rms = sqrt(mean(x^2) + EPS) and its reciprocal with sequential bitwise sqrt and restoring-divide engines.
- Streams y = x * (1/rms) back out as DIM/LANES output beats under valid/ready backpressure.

Parameters:
- DIM, 64: vector length; power of two, >= LANES.
- LANES, 8: elements per beat; DIM % LANES == 0.
- WIDTH, 16: signed element width.
- FRAC, 8: fractional bits of elements, rms_o and the reciprocal (Q(WIDTH-FRAC).FRAC).
- EPS, 1: unsigned constant added to the mean square, in units of 2^-(2*FRAC).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous assert, active-low.
- x_i  in  LANES*WIDTH  input beat; lane k at bits [k*WIDTH +: WIDTH].
- x_valid_i  in  1  input beat valid.
- x_ready_o  out  1  input beat accepted when x_valid_i && x_ready_o.
- y_o  out  LANES*WIDTH  normalised output beat.
- y_valid_o  out  1  output beat valid.
- y_ready_i  in  1  output consumer ready.
- y_last_o  out  1  high on the final beat of a vector.
- rms_o  out  WIDTH  rms of the most recent vector, Q.FRAC.
- busy_o  out  1  high in any state other than ACCUM with beat count 0.

Behaviour:
- Reset (async, rst_ni=0):
  - State = ACCUM, beat counters = 0, sum of squares = 0.
  - y_o = 0, y_valid_o = 0, y_last_o = 0, rms_o = 0, busy_o = 0, x_ready_o = 1 after release.
  - Reset asserted mid-operation discards any partial vector and any pending output.
- Beats: NB = DIM/LANES.
- State ACCUM:
  - x_ready_o = 1.
  - Each accepted beat is stored at buffer slot beat_cnt and adds the sum of its LANES squares to sum_sq.
  - sum_sq width: 2*WIDTH + clog2(DIM), no overflow possible.
  - On acceptance of beat NB-1, go to SQRT.
- State SQRT:
  - x_ready_o = 0.
  - ms = (sum_sq >> clog2(DIM)) + EPS; ms carries 2*FRAC fractional bits.
  - Bitwise integer sqrt, one result bit per cycle, exactly WIDTH cycles.
  - Result is clamped to 2^(WIDTH-1)-1 and registered to rms_o on exit. Go to RECIP.
- State RECIP:
  - Restoring divide inv = floor(2^(2*FRAC) / rms), one quotient bit per cycle, exactly WIDTH cycles.
  - inv saturates to 2^(WIDTH-1)-1; rms = 0 (only possible with EPS=0) also gives the saturated value, never X.
  - Go to EMIT.
- State EMIT:
  - Beat j lane k: y = sat_WIDTH((x[j][k] * inv) >>> FRAC); arithmetic shift, signed saturation to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - y_o, y_valid_o and y_last_o are registered.
  - y_o is held stable while y_valid_o && !y_ready_i.
  - The next beat loads on the same edge the current beat is accepted, so there are no bubbles under continuous ready.
  - y_last_o = 1 on beat NB-1. Its acceptance returns the block to ACCUM, with y_valid_o = 0 the following cycle.
- Latency: last input beat accepted at edge t -> y_valid_o first high after edge t + 2*WIDTH + 2.
- Throughput: one vector per NB + 2*WIDTH + 2 + NB cycles minimum; input and output phases do not overlap.
- rms_o changes only on SQRT exit and holds until the next SQRT exit.
- x_valid_i during SQRT, RECIP or EMIT is ignored (not accepted).

Optional Feature:
- Macro: RMS_NORM_GAIN_EN.
- When defined:
  - Adds input port gain_i, LANES*WIDTH, Q.FRAC signed per-lane gain.
  - gain_i is sampled on the same edge each output beat is loaded.
  - y = sat_WIDTH((sat_WIDTH((x*inv) >>> FRAC) * g) >>> FRAC).
  - Timing and latency are unchanged.
- When undefined: no gain_i port; y as in Behaviour.

Test Plan:
All tests use DIM=8, LANES=4, WIDTH=16, FRAC=8, EPS=1.
1. All x=256 (1.0) -> rms_o=256, inv=256, all y=256; y_last_o on beat 1 only; first y_valid_o exactly 34 cycles after last input beat.
2. Lanes alternate 768/-768 (+3.0/-3.0) -> rms_o=768, inv=85, y alternates 255/-255.
3. All-zero vector -> rms_o=1, inv saturates to 32767, all y=0, no X on any output.
4. All x=-32768 -> rms_o clamps to 32767, inv=2, y=-256; no wrap.
5. Backpressure: y_ready_i low 5 cycles on beat 0 -> y_o and y_valid_o stable, x_ready_o=0 throughout; a second vector is accepted only after beat 1 is taken.
6. Assert rst_ni after 1 of 2 input beats -> all outputs 0 asynchronously; a full fresh vector then produces test-1 results. Under RMS_NORM_GAIN_EN: test 1 with gain_i=128 gives y=128.

Source files
------------

// File: rtl/rms_norm_stream.sv
// Streaming RMS normaliser: buffers DIM/LANES beats, serial sqrt then divide for 1/rms, emits y = x/rms (RMS_NORM_GAIN_EN adds gain_i).
// Latency: last input beat accepted at edge t -> first y_valid_o after edge t + 2*WIDTH + 2; one output beat per cycle after that.
// Backpressure: x_ready_o only while accumulating; y_o/y_valid_o/y_last_o held while y_valid_o && !y_ready_i.
module rms_norm_stream #(
    parameter int          DIM   = 64,
    parameter int          LANES = 8,
    parameter int          WIDTH = 16,
    parameter int          FRAC  = 8,
    parameter int unsigned EPS   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [LANES*WIDTH-1:0] x_i,
    input  logic                   x_valid_i,
    output logic                   x_ready_o,
    output logic [LANES*WIDTH-1:0] y_o,
    output logic                   y_valid_o,
    input  logic                   y_ready_i,
`ifdef RMS_NORM_GAIN_EN
    input  logic [LANES*WIDTH-1:0] gain_i,
`endif
    output logic                   y_last_o,
    output logic [WIDTH-1:0]       rms_o,
    output logic                   busy_o
);
    localparam int NB      = DIM / LANES;
    localparam int BW      = (NB > 1) ? $clog2(NB) : 1;
    localparam int LOG_DIM = $clog2(DIM);
    localparam int SSW     = 2*WIDTH + LOG_DIM;
    localparam int CW      = $clog2(WIDTH + 1);

    localparam logic [1:0] ACCUM = 2'd0;
    localparam logic [1:0] SQRT  = 2'd1;
    localparam logic [1:0] RECIP = 2'd2;
    localparam logic [1:0] EMIT  = 2'd3;

    localparam logic [WIDTH-1:0]          SMAX    = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SMAX_X  = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [2*WIDTH-1:0] SMIN_X  = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0]        ONE_SQ  = {{(2*WIDTH-1){1'b0}}, 1'b1} << (2*FRAC);
    localparam logic [2*WIDTH-1:0]        EPS_X   = (2*WIDTH)'(EPS);
    localparam logic [BW-1:0]             LAST_BT = BW'(NB - 1);
    localparam logic [CW-1:0]             LAST_IT = CW'(WIDTH);

    function automatic logic [2*WIDTH-1:0] square(input logic [WIDTH-1:0] a);
        logic signed [2*WIDTH-1:0] e;
        e = $signed({{WIDTH{a[WIDTH-1]}}, a});
        return e * e;
    endfunction

    // Q.FRAC multiply with arithmetic rescale and signed saturation to WIDTH bits.
    function automatic logic [WIDTH-1:0] mul_frac(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic signed [2*WIDTH-1:0] p;
        p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
        p = p >>> FRAC;
        if (p > SMAX_X)
            return SMAX;
        else if (p < SMIN_X)
            return ~SMAX;
        return p[WIDTH-1:0];
    endfunction

    logic [1:0]             state;
    logic [BW-1:0]          in_cnt, out_cnt;
    logic [CW-1:0]          it_cnt;
    logic [SSW-1:0]         sum_sq, beat_sq;
    logic [2*WIDTH-1:0]     ms, op_q;
    logic [WIDTH+1:0]       sq_rem, sq_diff;
    logic [WIDTH+3:0]       sq_sh, sq_trial;
    logic                   sq_ge;
    logic [WIDTH-1:0]       root, root_n, root_cl;
    logic [WIDTH-1:0]       div_q, dv_rem, dv_diff, quo, quo_n, inv;
    logic [WIDTH:0]         dv_sh;
    logic                   dv_ge, inv_sat;
    logic [LANES*WIDTH-1:0] mem [NB];
    logic [LANES*WIDTH-1:0] beat_rd, y_d;
    logic                   x_acc, y_adv;

    assign x_ready_o = (state == ACCUM);
    assign x_acc     = x_valid_i && x_ready_o;
    assign busy_o    = (state != ACCUM) || (in_cnt != '0);
    assign y_adv     = !y_valid_o || y_ready_i;

    always_comb begin
        beat_sq = '0;
        for (int k = 0; k < LANES; k++)
            beat_sq = beat_sq + SSW'(square(x_i[k*WIDTH +: WIDTH]));
    end

    assign ms = (2*WIDTH)'(sum_sq >> LOG_DIM) + EPS_X;

    // Digit-by-digit square root: two radicand bits in, one root bit out per cycle.
    assign sq_sh    = {sq_rem, op_q[2*WIDTH-1 -: 2]};
    assign sq_trial = {2'b00, root, 2'b01};
    assign sq_ge    = (sq_sh >= sq_trial);
    assign sq_diff  = (WIDTH+2)'(sq_ge ? sq_sh - sq_trial : sq_sh);
    assign root_n   = {root[WIDTH-2:0], sq_ge};
    assign root_cl  = root_n[WIDTH-1] ? SMAX : root_n;

    // Restoring divide; quo starts as the dividend's low half and shifts quotient bits in.
    // The high half preloads the remainder, valid whenever the quotient fits, otherwise inv_sat overrides.
    assign dv_sh   = {dv_rem, quo[WIDTH-1]};
    assign dv_ge   = (dv_sh >= {1'b0, div_q});
    assign dv_diff = WIDTH'(dv_ge ? dv_sh - {1'b0, div_q} : dv_sh);
    assign quo_n   = {quo[WIDTH-2:0], dv_ge};
    assign inv_sat = ({1'b0, div_q, {(WIDTH-1){1'b0}}} <= ONE_SQ);

    assign beat_rd = mem[out_cnt];

    always_comb begin
        y_d = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef RMS_NORM_GAIN_EN
            y_d[k*WIDTH +: WIDTH] = mul_frac(mul_frac(beat_rd[k*WIDTH +: WIDTH], inv), gain_i[k*WIDTH +: WIDTH]);
`else
            y_d[k*WIDTH +: WIDTH] = mul_frac(beat_rd[k*WIDTH +: WIDTH], inv);
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (x_acc)
            mem[in_cnt] <= x_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= ACCUM;
            in_cnt    <= '0;
            out_cnt   <= '0;
            it_cnt    <= '0;
            sum_sq    <= '0;
            op_q      <= '0;
            sq_rem    <= '0;
            root      <= '0;
            div_q     <= '0;
            dv_rem    <= '0;
            quo       <= '0;
            inv       <= '0;
            y_o       <= '0;
            y_valid_o <= 1'b0;
            y_last_o  <= 1'b0;
            rms_o     <= '0;
        end else begin
            case (state)
                ACCUM: if (x_acc) begin
                    sum_sq <= (in_cnt == '0) ? beat_sq : sum_sq + beat_sq;
                    if (in_cnt == LAST_BT) begin
                        in_cnt <= '0;
                        it_cnt <= '0;
                        state  <= SQRT;
                    end else begin
                        in_cnt <= in_cnt + BW'(1);
                    end
                end
                SQRT: if (it_cnt == '0) begin
                    op_q   <= ms;
                    sq_rem <= '0;
                    root   <= '0;
                    it_cnt <= CW'(1);
                end else begin
                    op_q   <= op_q << 2;
                    sq_rem <= sq_diff;
                    root   <= root_n;
                    if (it_cnt == LAST_IT) begin
                        rms_o  <= root_cl;
                        div_q  <= root_cl;
                        dv_rem <= ONE_SQ[2*WIDTH-1:WIDTH];
                        quo    <= ONE_SQ[WIDTH-1:0];
                        it_cnt <= CW'(1);
                        state  <= RECIP;
                    end else begin
                        it_cnt <= it_cnt + CW'(1);
                    end
                end
                RECIP: begin
                    dv_rem <= dv_diff;
                    quo    <= quo_n;
                    if (it_cnt == LAST_IT) begin
                        inv     <= inv_sat ? SMAX : quo_n;
                        out_cnt <= '0;
                        state   <= EMIT;
                    end else begin
                        it_cnt <= it_cnt + CW'(1);
                    end
                end
                default: if (y_adv) begin
                    if (y_valid_o && y_last_o) begin
                        y_valid_o <= 1'b0;
                        y_last_o  <= 1'b0;
                        state     <= ACCUM;
                    end else begin
                        y_o       <= y_d;
                        y_valid_o <= 1'b1;
                        y_last_o  <= (out_cnt == LAST_BT);
                        out_cnt   <= out_cnt + BW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rms_norm_stream.sv
// Directed bench for rms_norm_stream at DIM=8, LANES=4, WIDTH=16, FRAC=8, EPS=1; expected values hand-computed.
module tb_rms_norm_stream;
    localparam int DIM = 8, LANES = 4, WIDTH = 16, FRAC = 8, EPS = 1;
    localparam int LAT = 2*WIDTH + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] x_dat = '0;
    logic        x_vld = 1'b0;
    logic        x_rdy;
    logic [63:0] y_dat;
    logic        y_vld;
    logic        y_rdy = 1'b1;
    logic        y_last;
    logic [15:0] rms;
    logic        busy;
`ifdef RMS_NORM_GAIN_EN
    logic [63:0] gain = {4{16'h0100}};
`endif

    int cyc = 0;
    int acc_cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    rms_norm_stream #(.DIM(DIM), .LANES(LANES), .WIDTH(WIDTH), .FRAC(FRAC), .EPS(EPS)) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .x_i       (x_dat),
        .x_valid_i (x_vld),
        .x_ready_o (x_rdy),
        .y_o       (y_dat),
        .y_valid_o (y_vld),
        .y_ready_i (y_rdy),
`ifdef RMS_NORM_GAIN_EN
        .gain_i    (gain),
`endif
        .y_last_o  (y_last),
        .rms_o     (rms),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Starts and ends at a negedge; acc_cyc is the cycle stamp of the accepting edge.
    task automatic send_beat(input logic [63:0] b);
        x_dat = b;
        x_vld = 1'b1;
        for (int i = 0; i < 200 && !x_rdy; i++) @(negedge clk);
        if (!x_rdy) chk("x_rdy_timeout", 64'(x_rdy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        acc_cyc = cyc;
        x_vld = 1'b0;
    endtask

    task automatic wait_yvld(input string tag);
        for (int i = 0; i < 200 && !y_vld; i++) @(negedge clk);
        if (!y_vld) chk({tag, "_yvld_timeout"}, 64'(y_vld), 64'd1);
    endtask

    task automatic get_beat(input string tag, input logic [63:0] exp, input logic exp_last);
        for (int i = 0; i < 200 && !(y_vld && y_rdy); i++) @(negedge clk);
        if (!(y_vld && y_rdy)) chk({tag, "_timeout"}, 64'(y_vld), 64'd1);
        chk({tag, "_dat"}, y_dat, exp);
        chk({tag, "_last"}, 64'(y_last), 64'(exp_last));
        @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input logic [63:0] b0, input logic [63:0] b1,
                           input logic [15:0] exp_rms, input logic [63:0] ey0, input logic [63:0] ey1);
        send_beat(b0);
        chk({tag, "_busy_mid"}, 64'(busy), 64'd1);
        send_beat(b1);
        chk({tag, "_x_rdy_calc"}, 64'(x_rdy), 64'd0);
        wait_yvld(tag);
        chk({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(LAT));
        chk({tag, "_rms"}, 64'(rms), 64'(exp_rms));
        get_beat({tag, "_b0"}, ey0, 1'b0);
        get_beat({tag, "_b1"}, ey1, 1'b1);
        chk({tag, "_yvld_end"}, 64'(y_vld), 64'd0);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_x_rdy_end"}, 64'(x_rdy), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] one;
        one = {4{16'h0100}};
        repeat (3) @(negedge clk);
        chk("rst_y_dat", y_dat, 64'd0);
        chk("rst_y_vld", 64'(y_vld), 64'd0);
        chk("rst_y_last", 64'(y_last), 64'd0);
        chk("rst_rms", 64'(rms), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_x_rdy", 64'(x_rdy), 64'd1);

        run_vec("t1", one, one, 16'h0100, one, one);
        run_vec("t2", {16'hFD00, 16'h0300, 16'hFD00, 16'h0300}, {16'hFD00, 16'h0300, 16'hFD00, 16'h0300},
                16'h0300, {16'hFF01, 16'h00FF, 16'hFF01, 16'h00FF}, {16'hFF01, 16'h00FF, 16'hFF01, 16'h00FF});
        run_vec("t3", 64'd0, 64'd0, 16'h0001, 64'd0, 64'd0);
        run_vec("t4", {4{16'h8000}}, {4{16'h8000}}, 16'h7FFF, {4{16'hFF00}}, {4{16'hFF00}});

        // Stall the first output beat while offering a competing input beat.
        y_rdy = 1'b0;
        send_beat(one);
        send_beat(one);
        wait_yvld("t5");
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold_dat", y_dat, one);
            chk("t5_hold_vld", 64'(y_vld), 64'd1);
            chk("t5_hold_x_rdy", 64'(x_rdy), 64'd0);
            x_dat = {4{16'h1234}};
            x_vld = 1'b1;
            @(negedge clk);
        end
        x_vld = 1'b0;
        y_rdy = 1'b1;
        get_beat("t5_b0", one, 1'b0);
        chk("t5_x_rdy_b1", 64'(x_rdy), 64'd0);
        get_beat("t5_b1", one, 1'b1);
        chk("t5_x_rdy_after", 64'(x_rdy), 64'd1);

        // Reset between input beats of a vector.
        send_beat(one);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_rms", 64'(rms), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_y_dat", y_dat, 64'd0);
        chk("t6_rst_y_vld", 64'(y_vld), 64'd0);
        chk("t6_rst_y_last", 64'(y_last), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_vec("t6", one, one, 16'h0100, one, one);

`ifdef RMS_NORM_GAIN_EN
        gain = {4{16'h0080}};
        run_vec("tg", one, one, 16'h0100, {4{16'h0080}}, {4{16'h0080}});
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
